// File: rtl/x_host_ctrl.sv
// Host-side controller for a byte-serial (UART) memory link.
// Each host access becomes up to three command bytes: a low address byte,
// a high address byte, and a write or read byte. The controller caches the
// auto-incremented address so that sequential accesses skip address bytes.
module x_host_ctrl #(
    parameter int p_timeout = 100000
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [10:0] i_req_addr,
    input  logic [5:0]  i_req_wdata,
    output logic        o_rsp_valid,
    output logic [5:0]  o_rsp_rdata,
    output logic        o_rsp_timeout,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    input  logic        i_cmd_accept,
    input  logic        i_rsp_valid,
    input  logic [7:0]  i_rsp
);

    localparam int CNT_W = (p_timeout > 1) ? $clog2(p_timeout) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_timeout - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE, ADDR_LO, ADDR_HI, OP, WAIT_RSP, DONE
    } state_t;

    state_t           state;
    logic             we_q;
    logic [10:0]      addr_q;
    logic [5:0]       wdata_q;
    logic [10:0]      cache_addr;
    logic             cache_valid;
    logic [CNT_W-1:0] cnt;

    // The response byte only carries six data bits; the top two are don't-care.
    logic unused_rsp_hi;
    assign unused_rsp_hi = ^i_rsp[7:6];

    // Command byte encodings.
    function automatic logic [7:0] cmd_lo(input logic [10:0] a);
        return {2'b00, a[5:0]};
    endfunction

    function automatic logic [7:0] cmd_hi(input logic [10:0] a);
        return {3'b010, a[10:6]};
    endfunction

    function automatic logic [7:0] cmd_op(input logic we, input logic [5:0] d);
        return we ? {2'b10, d} : 8'hC0;
    endfunction

    // An address byte can be skipped when its field already matches the
    // remote side's post-incremented address.
    logic lo_hit_req, hi_hit_req, hi_hit_q;
    assign lo_hit_req = cache_valid && (cache_addr[5:0]  == i_req_addr[5:0]);
    assign hi_hit_req = cache_valid && (cache_addr[10:6] == i_req_addr[10:6]);
    assign hi_hit_q   = cache_valid && (cache_addr[10:6] == addr_q[10:6]);

    assign o_req_ready = (state == IDLE);

    // Main sequencer: byte emission, response wait with timeout, completion.
    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the
        // clocked block and every state bit gets a defined value here.
        if (!i_nrst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cache_addr    <= '0;
            cache_valid   <= 1'b0;
            cnt           <= '0;
            o_cmd_valid   <= 1'b0;
            o_cmd         <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only; a default here followed by a
            // later override in the case body is the intended last-wins pulse.
            o_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q        <= i_req_we;
                        addr_q      <= i_req_addr;
                        wdata_q     <= i_req_wdata;
                        o_cmd_valid <= 1'b1;
                        if (!lo_hit_req) begin
                            state <= ADDR_LO;
                            o_cmd <= cmd_lo(i_req_addr);
                        end else if (!hi_hit_req) begin
                            state <= ADDR_HI;
                            o_cmd <= cmd_hi(i_req_addr);
                        end else begin
                            state <= OP;
                            o_cmd <= cmd_op(i_req_we, i_req_wdata);
                        end
                    end
                end
                ADDR_LO: begin
                    if (i_cmd_accept) begin
                        if (!hi_hit_q) begin
                            state <= ADDR_HI;
                            o_cmd <= cmd_hi(addr_q);
                        end else begin
                            state <= OP;
                            o_cmd <= cmd_op(we_q, wdata_q);
                        end
                    end
                end
                ADDR_HI: begin
                    if (i_cmd_accept) begin
                        state <= OP;
                        o_cmd <= cmd_op(we_q, wdata_q);
                    end
                end
                OP: begin
                    if (i_cmd_accept) begin
                        o_cmd_valid <= 1'b0;
                        o_cmd       <= '0;
                        if (we_q) begin
                            state         <= DONE;
                            o_rsp_valid   <= 1'b1;
                            o_rsp_rdata   <= '0;
                            o_rsp_timeout <= 1'b0;
                            cache_addr    <= addr_q + 11'd1;
                            cache_valid   <= 1'b1;
                        end else begin
                            state <= WAIT_RSP;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response arriving on the timeout cycle still counts.
                    if (i_rsp_valid) begin
                        state         <= DONE;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= i_rsp[5:0];
                        o_rsp_timeout <= 1'b0;
                        cache_addr    <= addr_q + 11'd1;
                        cache_valid   <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= '0;
                        o_rsp_timeout <= 1'b1;
                        cache_valid   <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_host_ctrl.sv
// Self-checking bench for x_host_ctrl: directed scenarios followed by
// randomized accesses compared against a transaction-level model.
module tb_x_host_ctrl;

    localparam int P_TO = 16;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [10:0] i_req_addr;
    logic [5:0]  i_req_wdata;
    logic        o_rsp_valid;
    logic [5:0]  o_rsp_rdata;
    logic        o_rsp_timeout;
    logic        o_cmd_valid;
    logic [7:0]  o_cmd;
    logic        i_cmd_accept;
    logic        i_rsp_valid;
    logic [7:0]  i_rsp;

    x_host_ctrl #(.p_timeout(P_TO)) dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_timeout(o_rsp_timeout),
        .o_cmd_valid  (o_cmd_valid),
        .o_cmd        (o_cmd),
        .i_cmd_accept (i_cmd_accept),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp        (i_rsp)
    );

    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: what the remote side's address pointer holds, if known.
    logic [10:0] m_cache;
    bit          m_cv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete host access. rsp_delay: 0 = no response (timeout), else the
    // response is presented on the rsp_delay-th clock after the read byte.
    task automatic access(input bit we, input logic [10:0] addr, input logic [5:0] wdata,
                          input int rsp_delay, input logic [7:0] rsp_byte,
                          input int acc_pct, input int first_stall, input bit junk_req,
                          output int n_bytes);
        logic [7:0] exp_q[$];
        int         k_exp;
        bit         exp_to;
        logic [5:0] exp_rd;
        int         idx   = 0;
        int         stall = first_stall;
        int         since = -1;
        int         cyc   = 0;
        int         guard = 0;
        bit         last_sent = 0;
        bit         done = 0;
        bit         acc;

        // Expected byte stream from the encoding rules.
        if (!m_cv || m_cache[5:0] != addr[5:0])   exp_q.push_back({2'b00, addr[5:0]});
        if (!m_cv || m_cache[10:6] != addr[10:6]) exp_q.push_back({3'b010, addr[10:6]});
        exp_q.push_back(we ? {2'b10, wdata} : 8'hC0);

        if (we) begin
            k_exp = 0; exp_to = 0; exp_rd = 6'd0;
        end else if (rsp_delay >= 1 && rsp_delay <= P_TO) begin
            k_exp = rsp_delay; exp_to = 0; exp_rd = rsp_byte[5:0];
        end else begin
            k_exp = P_TO; exp_to = 1; exp_rd = 6'd0;
        end

        while (!o_req_ready && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        check("req_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        @(negedge i_clk);
        if (junk_req) begin
            i_req_we    = 1'($urandom_range(1));
            i_req_addr  = 11'($urandom);
            i_req_wdata = 6'($urandom);
        end else begin
            i_req_valid = 1'b0;
        end

        while (!done && cyc < 200) begin
            if (since < 0) begin
                check("rsp_early", o_rsp_valid, 0);
                check("cmd_valid", o_cmd_valid, 1);
                check("req_busy", o_req_ready, 0);
                if (idx < exp_q.size()) check("cmd_byte", o_cmd, exp_q[idx]);
                else                    check("cmd_extra", idx, exp_q.size() - 1);
                if (stall > 0) begin
                    acc = 0;
                    stall--;
                end else begin
                    acc = ($urandom_range(99) < acc_pct);
                end
                i_cmd_accept = acc;
                // Stray response bytes outside the wait phase must be ignored.
                i_rsp_valid = 1'($urandom_range(1));
                i_rsp       = 8'($urandom);
                if (acc && o_cmd_valid) begin
                    idx++;
                    if (idx == exp_q.size()) last_sent = 1;
                end
            end else begin
                check("cmd_quiet", o_cmd_valid, 0);
                check("rsp_valid", o_rsp_valid, (since == k_exp));
                i_cmd_accept = 1'($urandom_range(1));
                if (since == k_exp) begin
                    check("rsp_rdata", o_rsp_rdata, exp_rd);
                    check("rsp_timeout", o_rsp_timeout, exp_to);
                    i_req_valid = 1'b0;
                    done = 1;
                end
                if (!we && rsp_delay >= 1 && since + 1 == rsp_delay) begin
                    i_rsp_valid = 1'b1;
                    i_rsp       = rsp_byte;
                end else begin
                    i_rsp_valid = 1'b0;
                end
            end
            @(negedge i_clk);
            cyc++;
            if (last_sent) since++;
        end
        check("access_budget", done, 1);
        i_rsp_valid  = 1'b0;
        i_cmd_accept = 1'b0;
        i_req_valid  = 1'b0;
        check("rsp_pulse_end", o_rsp_valid, 0);
        check("ready_after", o_req_ready, 1);
        check("rdata_hold", o_rsp_rdata, exp_rd);

        if (exp_to) m_cv = 0;
        else begin
            m_cache = addr + 11'd1;
            m_cv    = 1;
        end
        n_bytes = idx;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, o_cmd_valid, 0);
        check({tag, "_cmd"}, o_cmd, 0);
        check({tag, "_rsp_valid"}, o_rsp_valid, 0);
        check({tag, "_rdata"}, o_rsp_rdata, 0);
        check({tag, "_timeout"}, o_rsp_timeout, 0);
    endtask

    // Start a read, let it reach the response wait, then reset it away.
    task automatic reset_during_wait();
        int guard = 0;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 11'h200;
        i_req_wdata = 6'd0;
        @(negedge i_clk);
        i_req_valid  = 1'b0;
        i_cmd_accept = 1'b1;
        while (o_cmd_valid && guard < 10) begin
            @(negedge i_clk);
            guard++;
        end
        check("rst_reach_wait", o_cmd_valid, 0);
        i_cmd_accept = 1'b0;
        repeat (3) @(negedge i_clk);
        i_nrst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            check_reset_outputs("rst_mid");
        end
        i_nrst = 1'b1;
        @(negedge i_clk);
        check("rst_ready", o_req_ready, 1);
        check("rst_no_pulse", o_rsp_valid, 0);
        i_rsp_valid = 1'b1;
        i_rsp       = 8'h3F;
        @(negedge i_clk);
        i_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rst_late_rsp", o_rsp_valid, 0);
            check("rst_late_ready", o_req_ready, 1);
            @(negedge i_clk);
        end
        check("rst_rdata_clear", o_rsp_rdata, 0);
        m_cv = 0;
    endtask

    initial begin
        int nb;
        i_nrst       = 1'b0;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_addr   = '0;
        i_req_wdata  = '0;
        i_cmd_accept = 1'b0;
        i_rsp_valid  = 1'b0;
        i_rsp        = '0;
        m_cache      = '0;
        m_cv         = 0;

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_nrst = 1'b1;
        @(negedge i_clk);
        check("reset_ready", o_req_ready, 1);

        // Write 0x2A at 0x0A5 with the transmitter always ready.
        access(1'b1, 11'h0A5, 6'h2A, 0, 8'h00, 100, 0, 1'b0, nb);
        check("s1_bytes", nb, 3);
        // Sequential read: only the op byte; upper response bits dropped.
        access(1'b0, 11'h0A6, 6'h00, 3, 8'hD5, 100, 0, 1'b0, nb);
        check("s2_bytes", nb, 1);
        check("s2_rdata", o_rsp_rdata, 6'h15);
        // Transmitter stalls five cycles on the first byte.
        access(1'b1, 11'h123, 6'h11, 0, 8'h00, 100, 5, 1'b1, nb);
        check("s3_bytes", nb, 3);
        // Timed-out read, then the next access must resend both address bytes.
        access(1'b0, 11'h124, 6'h00, 0, 8'h00, 100, 0, 1'b0, nb);
        check("s4_timeout", o_rsp_timeout, 1);
        access(1'b1, 11'h125, 6'h05, 0, 8'h00, 100, 0, 1'b0, nb);
        check("s4_resend", nb, 3);
        check("s4_timeout_clr", o_rsp_timeout, 0);
        // Address wrap, with the response arriving on the timeout cycle.
        access(1'b1, 11'h7FF, 6'h3F, 0, 8'h00, 100, 0, 1'b0, nb);
        access(1'b0, 11'h000, 6'h00, P_TO, 8'h6B, 100, 0, 1'b0, nb);
        check("s5_wrap_bytes", nb, 1);
        check("s5_tie_timeout", o_rsp_timeout, 0);
        // Reset in the middle of a read.
        reset_during_wait();
        access(1'b0, 11'h201, 6'h00, 2, 8'h81, 100, 0, 1'b0, nb);
        check("s6_after_reset", nb, 3);

        // Randomized traffic, biased toward sequential addresses.
        for (int t = 0; t < 300; t++) begin
            logic [10:0] a;
            bit          w;
            a = ($urandom_range(99) < 50) ? m_cache : 11'($urandom);
            w = 1'($urandom_range(1));
            access(w, a, 6'($urandom), $urandom_range(0, P_TO), 8'($urandom),
                   60, $urandom_range(0, 3), 1'($urandom_range(1)), nb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/x_host_ctrl.md
X_HOST_CTRL -- requirements
Module: x_host_ctrl

Interface
REQ-001 The module SHALL provide parameter p_timeout, default 100000, meaning the number of cycles to wait for a read response byte before aborting.
REQ-002 The module SHALL provide port i_clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 The module SHALL provide port i_nrst, input, 1, reset; reset is synchronous and active-low.
REQ-004 The module SHALL provide port i_req_valid, input, 1, meaning a host access request is present.
REQ-005 The module SHALL provide port o_req_ready, output, 1, meaning a request can be accepted.
REQ-006 The module SHALL provide port i_req_we, input, 1, meaning the request is a write (1) or a read (0).
REQ-007 The module SHALL provide port i_req_addr, input, 11, the memory address of the request.
REQ-008 The module SHALL provide port i_req_wdata, input, 6, the write data.
REQ-009 The module SHALL provide port o_rsp_valid, output, 1, a one-cycle completion pulse.
REQ-010 The module SHALL provide port o_rsp_rdata, output, 6, the read data.
REQ-011 The module SHALL provide port o_rsp_timeout, output, 1, meaning the completed access timed out.
REQ-012 The module SHALL provide port o_cmd_valid, output, 1, meaning a command byte is offered to the UART transmitter.
REQ-013 The module SHALL provide port o_cmd, output, 8, the command byte.
REQ-014 The module SHALL provide port i_cmd_accept, input, 1, meaning the transmitter takes the byte this cycle.
REQ-015 The module SHALL provide port i_rsp_valid, input, 1, meaning a response byte has arrived from the UART receiver.
REQ-016 The module SHALL provide port i_rsp, input, 8, the response byte.

Function
REQ-017 Command bytes SHALL be encoded as follows: [7:6]=00 sets address [5:0] from payload [5:0]; 01 sets address [10:6] from payload [4:0] with payload [5]=0; 10 writes payload [5:0] and post-increments the address; 11 reads with payload 0 and post-increments the address.
REQ-018 The FSM SHALL use the states IDLE, ADDR_LO, ADDR_HI, OP, WAIT_RSP and DONE.
REQ-019 o_req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted when i_req_valid and o_req_ready are both 1; i_req_we, i_req_addr and i_req_wdata SHALL be latched on acceptance.
REQ-021 On acceptance the FSM SHALL go to ADDR_LO, then ADDR_HI, then OP, skipping each address state whose field equals the cached next address while the cache is valid.
REQ-022 In each byte state, o_cmd_valid SHALL be 1 and o_cmd SHALL be stable until the cycle where i_cmd_accept=1; the FSM advances on the cycle after that.
REQ-023 After the write byte in OP is accepted, the FSM SHALL go to DONE; after the read byte is accepted, it SHALL go to WAIT_RSP and clear the timeout counter.
REQ-024 In WAIT_RSP, if i_rsp_valid=1, the FSM SHALL latch i_rsp[5:0] into o_rsp_rdata and go to DONE; upper bits [7:6] are ignored.
REQ-025 In WAIT_RSP, if the counter reaches p_timeout-1 with no response, the FSM SHALL set o_rsp_timeout=1, set o_rsp_rdata=0, invalidate the address cache and go to DONE.
REQ-026 If i_rsp_valid and the timeout occur in the same cycle, the response SHALL win.
REQ-027 In DONE, o_rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; for writes, o_rsp_rdata=0 and o_rsp_timeout=0.
REQ-028 o_rsp_rdata and o_rsp_timeout SHALL hold their values until the next DONE.
REQ-029 On a non-timeout completion, the cache SHALL be set to (addr+1) mod 2048 and marked valid; 2047 wraps to 0.
REQ-030 The timeout counter SHALL be at least clog2(p_timeout) bits wide and SHALL saturate.
REQ-031 i_rsp_valid outside WAIT_RSP SHALL be ignored with no state change.
REQ-032 i_req_valid while not in IDLE SHALL be ignored and not queued.

Reset
REQ-033 With i_nrst=0 at a clock edge, the FSM SHALL go to IDLE, the cache SHALL be invalidated, and the counter SHALL be cleared.
REQ-034 During reset, o_cmd_valid=0, o_cmd=0, o_rsp_valid=0, o_rsp_rdata=0 and o_rsp_timeout=0; o_req_ready SHALL be 1 from the first cycle after reset releases.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer with no o_rsp_valid pulse.

Verification
REQ-036 Scenario: after reset, write addr 0x0A5, data 0x2A, i_cmd_accept held 1 -> bytes 0x25, 0x42, 0xAA, then one o_rsp_valid pulse with timeout=0.
REQ-037 Scenario: next read at addr 0x0A6 -> only byte 0xC0 is sent; i_rsp=0xD5 -> o_rsp_rdata=0x15, o_rsp_valid pulse.
REQ-038 Scenario: i_cmd_accept low for 5 cycles -> o_cmd_valid stays 1 with o_cmd stable, and no byte is lost or duplicated.
REQ-039 Scenario: read with no response, p_timeout=16 -> o_rsp_timeout=1 and rdata=0 after 16 cycles in WAIT_RSP; the next access resends both address bytes.
REQ-040 Scenario: access at 0x7FF then at 0x000 -> the second access sends no address bytes (wrap).
REQ-041 Scenario: reset pulsed during WAIT_RSP -> no o_rsp_valid pulse, o_req_ready=1, and a later i_rsp_valid is ignored.
